// File: rtl/router_pkt_tx_if.sv
// ---------------------------------------------------------------------------
// router_pkt_tx_if
// Bundle of the request, payload and router-side signals of router_pkt_tx.
//   request : req_valid/req_ready handshake with req_addr, req_len, req_corrupt
//   payload : pay_valid/pay_ready handshake with pay_data
//   router  : busy, error in; pkt_valid, data_out out
//   status  : req_err, pkt_done, pkt_err pulses
// Modport slave is the transmitter's view, master the traffic source's view.
// ---------------------------------------------------------------------------
interface router_pkt_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_corrupt;
  logic       pay_valid;
  logic       pay_ready;
  logic [7:0] pay_data;
  logic       busy;
  logic       error;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       req_err;
  logic       pkt_done;
  logic       pkt_err;

  modport slave (
    input  req_valid, req_addr, req_len, req_corrupt,
    input  pay_valid, pay_data,
    input  busy, error,
    output req_ready, pay_ready,
    output pkt_valid, data_out,
    output req_err, pkt_done, pkt_err
  );

  modport master (
    output req_valid, req_addr, req_len, req_corrupt,
    output pay_valid, pay_data,
    output busy, error,
    input  req_ready, pay_ready,
    input  pkt_valid, data_out,
    input  req_err, pkt_done, pkt_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Collects a request (addr, len) and its payload into a 64-byte buffer, then
// sends header, payload and parity to the 1x3 router, honouring busy.
// Ports:
//   clk     : clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : router_pkt_tx_if.slave (request, payload, router, status)
// Parameter:
//   GAP     : idle cycles after the parity byte before IDLE (>= 1)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// LOAD    | pay_ready high, filling buffer and running parity
// HEADER  | header driven with pkt_valid, waiting for busy low
// PAYLOAD | buffer bytes driven with pkt_valid, advancing on busy low
// PARITY  | parity driven with pkt_valid low, waiting for busy low
// GAP     | idle countdown, then pkt_done / pkt_err
// ---------------------------------------------------------------------------
module router_pkt_tx #(
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  localparam int            GW       = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP);

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [5:0]      len_q, len_d;
  logic            corrupt_q, corrupt_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      scnt_q, scnt_d;
  logic [7:0]      par_q, par_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            err_flag_q, err_flag_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            req_err_q, req_err_d;
  logic            pkt_done_q, pkt_done_d;
  logic            pkt_err_q, pkt_err_d;
  logic            buf_we;
  logic [7:0]      buf_q [64];

  logic [5:0]      cnt_inc;
  logic [5:0]      scnt_inc;

  assign cnt_inc  = cnt_q + 6'd1;
  assign scnt_inc = scnt_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    corrupt_d   = corrupt_q;
    cnt_d       = cnt_q;
    scnt_d      = scnt_q;
    par_d       = par_q;
    gap_d       = gap_q;
    err_flag_d  = err_flag_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    req_err_d   = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_addr == 2'd3 || bus.req_len == 6'd0) begin
            req_err_d = 1'b1;
          end else begin
            addr_d    = bus.req_addr;
            len_d     = bus.req_len;
            corrupt_d = bus.req_corrupt;
            cnt_d     = 6'd0;
            par_d     = {bus.req_len, bus.req_addr};
            state_d   = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (bus.pay_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ bus.pay_data;
          cnt_d  = cnt_inc;
          // Outputs are registered, so the header is launched on the same
          // edge that takes the last payload byte.
          if (cnt_inc == len_q) begin
            state_d     = S_HEADER;
            scnt_d      = 6'd0;
            err_flag_d  = 1'b0;
            pkt_valid_d = 1'b1;
            data_out_d  = {len_q, addr_q};
          end
        end
      end

      S_HEADER: begin
        if (!bus.busy) begin
          state_d    = S_PAYLOAD;
          data_out_d = buf_q[scnt_q];
        end
      end

      S_PAYLOAD: begin
        if (!bus.busy) begin
          if (scnt_q == len_q - 6'd1) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = par_q ^ {7'd0, corrupt_q};
          end else begin
            scnt_d     = scnt_inc;
            data_out_d = buf_q[scnt_inc];
          end
        end
      end

      S_PARITY: begin
        if (bus.error) err_flag_d = 1'b1;
        if (!bus.busy) begin
          state_d    = S_GAP;
          gap_d      = GAP_INIT;
          data_out_d = 8'd0;
        end
      end

      S_GAP: begin
        if (bus.error) err_flag_d = 1'b1;
        gap_d = gap_q - GW'(1);
        // Terminal count: error seen on this last edge still counts.
        if (gap_q == GW'(1)) begin
          state_d    = S_IDLE;
          pkt_done_d = 1'b1;
          pkt_err_d  = err_flag_q | bus.error;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      corrupt_q   <= 1'b0;
      cnt_q       <= 6'd0;
      scnt_q      <= 6'd0;
      par_q       <= 8'd0;
      gap_q       <= '0;
      err_flag_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'd0;
      req_err_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      corrupt_q   <= corrupt_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      par_q       <= par_d;
      gap_q       <= gap_d;
      err_flag_q  <= err_flag_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      req_err_q   <= req_err_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  // Payload storage needs no reset; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q] <= bus.pay_data;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.pay_ready = (state_q == S_LOAD);
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.req_err   = req_err_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;
  localparam int GAP    = 2;
  localparam int CAPMAX = 128;

  logic clk;
  logic resetn;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.GAP(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [7:0] pay_mem [64];
  logic       cap_v    [CAPMAX];
  logic [7:0] cap_d    [CAPMAX];
  logic       cap_err  [CAPMAX];
  int         cap_n;
  logic       exp_v    [CAPMAX];
  logic [7:0] exp_d    [CAPMAX];
  int         exp_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_request(input logic [1:0] a, input logic [5:0] l,
                            input logic c, output bit ok);
    int n;
    n = 0;
    bus.req_valid   = 1'b1;
    bus.req_addr    = a;
    bus.req_len     = l;
    bus.req_corrupt = c;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    ok = bus.req_ready;
    tick();
    bus.req_valid   = 1'b0;
    bus.req_corrupt = 1'b0;
  endtask

  task automatic load_payload(input int l, input bit toggle, output bit ok);
    int n;
    ok = 1'b1;
    for (int k = 0; k < l; k++) begin
      if (toggle && (k % 2 == 1)) begin
        bus.pay_valid = 1'b0;
        tick();
      end
      bus.pay_valid = 1'b1;
      bus.pay_data  = pay_mem[k];
      n = 0;
      while (!bus.pay_ready && n < 20) begin
        tick();
        n++;
      end
      if (!bus.pay_ready) ok = 1'b0;
      tick();
    end
    bus.pay_valid = 1'b0;
  endtask

  // Records one observation per cycle until pkt_done; busy is high for the
  // first busy_n cycles, error high only in cycle err_idx.
  task automatic capture(input int busy_n, input int err_idx);
    cap_n = -1;
    for (int i = 0; i < CAPMAX; i++) begin
      cap_v[i]   = bus.pkt_valid;
      cap_d[i]   = bus.data_out;
      cap_err[i] = bus.pkt_err;
      if (bus.pkt_done) begin
        cap_n = i;
        break;
      end
      bus.busy  = (i < busy_n);
      bus.error = (i == err_idx);
      tick();
    end
    bus.busy  = 1'b0;
    bus.error = 1'b0;
  endtask

  // Reference stream: header (repeated while busy), payload, parity, gap.
  task automatic build_exp(input logic [1:0] a, input logic [5:0] l,
                           input logic c, input int busy_n);
    logic [7:0] hdr;
    logic [7:0] par;
    int idx;
    hdr = {l, a};
    par = hdr;
    for (int k = 0; k < int'(l); k++) par = par ^ pay_mem[k];
    if (c) par = par ^ 8'h01;
    idx = 0;
    for (int i = 0; i <= busy_n; i++) begin
      exp_v[idx] = 1'b1; exp_d[idx] = hdr; idx++;
    end
    for (int k = 0; k < int'(l); k++) begin
      exp_v[idx] = 1'b1; exp_d[idx] = pay_mem[k]; idx++;
    end
    exp_v[idx] = 1'b0; exp_d[idx] = par; idx++;
    for (int g = 0; g < GAP; g++) begin
      exp_v[idx] = 1'b0; exp_d[idx] = 8'h00; idx++;
    end
    exp_done = idx;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.req_ready, bus.pay_ready, bus.pkt_valid, bus.req_err,
         bus.pkt_done, bus.pkt_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got rr,pr,pv,re,pd,pe=%b exp 100000",
               {bus.req_ready, bus.pay_ready, bus.pkt_valid, bus.req_err,
                bus.pkt_done, bus.pkt_err});
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got %h exp 00", bus.data_out);
    end
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    for (int k = 0; k < 4; k++) pay_mem[k] = 8'(k + 1);
    do_request(2'd1, 6'd4, 1'b0, ok1);
    load_payload(4, 1'b0, ok2);
    checks++;
    if ({ok1, ok2} !== 2'b11) begin
      failures++;
      $display("FAIL basic_handshake got %b exp 11", {ok1, ok2});
    end
    checks++;
    if ({bus.pkt_valid, bus.data_out} !== {1'b1, 8'h11}) begin
      failures++;
      $display("FAIL basic_hdr_latency got v=%b d=%h exp v=1 d=11",
               bus.pkt_valid, bus.data_out);
    end
    capture(0, -1);
    build_exp(2'd1, 6'd4, 1'b0, 0);
    checks++;
    if (cap_n !== 8) begin
      failures++;
      $display("FAIL basic_done_idx got %0d exp 8", cap_n);
    end
    for (int i = 0; i < exp_done; i++) begin
      checks++;
      if ({cap_v[i], cap_d[i]} !== {exp_v[i], exp_d[i]}) begin
        failures++;
        $display("FAIL basic_stream[%0d] got v=%b d=%h exp v=%b d=%h",
                 i, cap_v[i], cap_d[i], exp_v[i], exp_d[i]);
      end
    end
    checks++;
    if (cap_d[5] !== 8'h15 || cap_err[8] !== 1'b0) begin
      failures++;
      $display("FAIL basic_parity_err got par=%h err=%b exp par=15 err=0",
               cap_d[5], cap_err[8]);
    end
  endtask

  task automatic test_busy_hold();
    bit ok1, ok2;
    for (int k = 0; k < 4; k++) pay_mem[k] = 8'(k + 1);
    do_request(2'd1, 6'd4, 1'b0, ok1);
    load_payload(4, 1'b0, ok2);
    capture(3, -1);
    build_exp(2'd1, 6'd4, 1'b0, 3);
    checks++;
    if (cap_n !== 11 || {ok1, ok2} !== 2'b11) begin
      failures++;
      $display("FAIL busy_done_idx got %0d hs=%b exp 11 hs=11", cap_n, {ok1, ok2});
    end
    for (int i = 0; i < exp_done; i++) begin
      checks++;
      if ({cap_v[i], cap_d[i]} !== {exp_v[i], exp_d[i]}) begin
        failures++;
        $display("FAIL busy_stream[%0d] got v=%b d=%h exp v=%b d=%h",
                 i, cap_v[i], cap_d[i], exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_illegal(input logic [1:0] a, input logic [5:0] l);
    bit ok;
    int bad;
    do_request(a, l, 1'b0, ok);
    checks++;
    if ({ok, bus.req_err, bus.req_ready, bus.pay_ready} !== 4'b1110) begin
      failures++;
      $display("FAIL illegal_pulse a=%0d l=%0d got ok,re,rr,pr=%b exp 1110",
               a, l, {ok, bus.req_err, bus.req_ready, bus.pay_ready});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.req_err || bus.pay_ready || bus.pkt_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL illegal_quiet a=%0d l=%0d got %0d active cycles exp 0",
               a, l, bad);
    end
  endtask

  task automatic test_long();
    bit ok1, ok2;
    for (int k = 0; k < 63; k++) pay_mem[k] = 8'(k);
    do_request(2'd2, 6'd63, 1'b0, ok1);
    load_payload(63, 1'b1, ok2);
    capture(0, -1);
    build_exp(2'd2, 6'd63, 1'b0, 0);
    checks++;
    if (cap_n !== 67 || {ok1, ok2} !== 2'b11) begin
      failures++;
      $display("FAIL long_done_idx got %0d hs=%b exp 67 hs=11", cap_n, {ok1, ok2});
    end
    checks++;
    if (cap_d[0] !== 8'hFE || cap_d[64] !== 8'hC1) begin
      failures++;
      $display("FAIL long_hdr_par got hdr=%h par=%h exp hdr=fe par=c1",
               cap_d[0], cap_d[64]);
    end
    for (int i = 0; i < exp_done; i++) begin
      checks++;
      if ({cap_v[i], cap_d[i]} !== {exp_v[i], exp_d[i]}) begin
        failures++;
        $display("FAIL long_stream[%0d] got v=%b d=%h exp v=%b d=%h",
                 i, cap_v[i], cap_d[i], exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_corrupt_err();
    bit ok1, ok2;
    for (int k = 0; k < 4; k++) pay_mem[k] = 8'(k + 1);
    do_request(2'd1, 6'd4, 1'b1, ok1);
    load_payload(4, 1'b0, ok2);
    capture(0, 6);
    build_exp(2'd1, 6'd4, 1'b1, 0);
    checks++;
    if (cap_n !== 8 || {ok1, ok2} !== 2'b11) begin
      failures++;
      $display("FAIL corrupt_done_idx got %0d hs=%b exp 8 hs=11", cap_n, {ok1, ok2});
    end
    checks++;
    if (cap_d[5] !== 8'h14) begin
      failures++;
      $display("FAIL corrupt_parity got %h exp 14", cap_d[5]);
    end
    checks++;
    if (cap_err[8] !== 1'b1 || cap_err[7] !== 1'b0) begin
      failures++;
      $display("FAIL corrupt_pkt_err got at8=%b at7=%b exp at8=1 at7=0",
               cap_err[8], cap_err[7]);
    end
    for (int i = 0; i < exp_done; i++) begin
      checks++;
      if ({cap_v[i], cap_d[i]} !== {exp_v[i], exp_d[i]}) begin
        failures++;
        $display("FAIL corrupt_stream[%0d] got v=%b d=%h exp v=%b d=%h",
                 i, cap_v[i], cap_d[i], exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    for (int k = 0; k < 4; k++) pay_mem[k] = 8'(k + 1);
    do_request(2'd1, 6'd4, 1'b0, ok1);
    load_payload(4, 1'b0, ok2);
    tick(); tick(); tick();
    checks++;
    if ({bus.pkt_valid, bus.data_out} !== {1'b1, 8'h03}) begin
      failures++;
      $display("FAIL midrst_before got v=%b d=%h exp v=1 d=03",
               bus.pkt_valid, bus.data_out);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.pkt_valid, bus.data_out, bus.req_ready, bus.pay_ready} !==
        {1'b0, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async got v=%b d=%h rr=%b pr=%b exp v=0 d=00 rr=1 pr=0",
               bus.pkt_valid, bus.data_out, bus.req_ready, bus.pay_ready);
    end
    tick();
    resetn = 1'b1;
    tick();
    pay_mem[0] = 8'hAA;
    pay_mem[1] = 8'h55;
    do_request(2'd0, 6'd2, 1'b0, ok1);
    load_payload(2, 1'b0, ok2);
    capture(0, -1);
    build_exp(2'd0, 6'd2, 1'b0, 0);
    checks++;
    if (cap_n !== 6 || cap_d[0] !== 8'h08 || cap_d[3] !== 8'hF7) begin
      failures++;
      $display("FAIL midrst_after got done=%0d hdr=%h par=%h exp done=6 hdr=08 par=f7",
               cap_n, cap_d[0], cap_d[3]);
    end
    for (int i = 0; i < exp_done; i++) begin
      checks++;
      if ({cap_v[i], cap_d[i]} !== {exp_v[i], exp_d[i]}) begin
        failures++;
        $display("FAIL midrst_stream[%0d] got v=%b d=%h exp v=%b d=%h",
                 i, cap_v[i], cap_d[i], exp_v[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    resetn          = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 2'd0;
    bus.req_len     = 6'd0;
    bus.req_corrupt = 1'b0;
    bus.pay_valid   = 1'b0;
    bus.pay_data    = 8'd0;
    bus.busy        = 1'b0;
    bus.error       = 1'b0;
    tick();
    tick();
    test_reset();
    resetn = 1'b1;
    tick();
    test_reset();
    test_corrupt_err();
    test_basic();
    test_busy_hold();
    test_illegal(2'd3, 6'd4);
    test_illegal(2'd0, 6'd0);
    test_long();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
